// File: rtl/spi_flash_reader.sv
// SPI mode-0 serial-flash read engine: issues READ at an address and streams 32-bit little-endian words.
// Define FLASH_READER_FAST_READ_EN to use the 0x0B fast-read command with 8 dummy clocks.
module spi_flash_reader #(
    parameter int STARTUP_WAIT = 1_000_000,
    parameter int CLK_DIV      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] start_address,
    input  logic [31:0] byte_count,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        ready_for_cmd,
    output logic        done,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs,
    output logic [2:0]  dbg_state
);

`ifdef FLASH_READER_FAST_READ_EN
    localparam int SEND_BITS = 40;
`else
    localparam int SEND_BITS = 32;
`endif
    localparam logic [31:0] STARTUP_LAST  = 32'(STARTUP_WAIT);
    localparam logic [15:0] DIV_LAST      = 16'(CLK_DIV - 1);
    localparam logic [5:0]  SEND_LAST_BIT = 6'(SEND_BITS - 1);

    typedef enum logic [2:0] {
        S_STARTUP, S_IDLE, S_SEND, S_READ, S_HOLD, S_ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [15:0]            div_q, div_d;
    logic                   phase_q, phase_d;
    logic [5:0]             bit_q, bit_d;
    logic [SEND_BITS-1:0]   sh_q, sh_d;
    logic [SEND_BITS-1:0]   cmd_load;
    logic [7:0]             byte_q, byte_d;
    logic [31:0]            asm_q, asm_d;
    logic [31:0]            rem_q, rem_d;
    logic [31:0]            word_q, word_d;
    logic [31:0]            req_bytes;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_q, cs_d;

    // Dummy byte is shifted out as zeros, so it rides on the command shifter.
`ifdef FLASH_READER_FAST_READ_EN
    assign cmd_load = {8'h0B, start_address, 8'h00};
`else
    assign cmd_load = {8'h03, start_address};
`endif
    assign req_bytes = byte_count & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STARTUP;
            cnt_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            sh_q    <= '0;
            byte_q  <= '0;
            asm_q   <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            asm_q   <= asm_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        byte_d  = byte_q;
        asm_d   = asm_q;
        rem_d   = rem_q;
        word_d  = word_q;
        valid_d = valid_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;

        case (state_q)
            S_STARTUP: begin
                if (cnt_q == STARTUP_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    ready_d = 1'b0;
                    rem_d   = req_bytes;
                    if (req_bytes == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cs_d    = 1'b0;
                        sh_d    = cmd_load;
                        mosi_d  = cmd_load[SEND_BITS-1];
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        div_d   = '0;
                        bit_d   = SEND_LAST_BIT;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 16'd1;
                end else if (!phase_q) begin
                    div_d   = '0;
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    div_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    if (bit_q == 6'd0) begin
                        mosi_d  = 1'b0;
                        bit_d   = 6'd31;
                        state_d = S_READ;
                    end else begin
                        sh_d   = {sh_q[SEND_BITS-2:0], 1'b0};
                        mosi_d = sh_q[SEND_BITS-2];
                        bit_d  = bit_q - 6'd1;
                    end
                end
            end
            S_READ: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 16'd1;
                end else if (!phase_q) begin
                    // Sample on the edge that raises flash_clk; bytes arrive MSB first.
                    div_d   = '0;
                    phase_d = 1'b1;
                    sclk_d  = 1'b1;
                    byte_d  = {byte_q[6:0], flash_miso};
                    if (bit_q[2:0] == 3'd0) begin
                        case (bit_q[4:3])
                            2'd3:    asm_d[7:0]   = byte_d;
                            2'd2:    asm_d[15:8]  = byte_d;
                            2'd1:    asm_d[23:16] = byte_d;
                            default: asm_d[31:24] = byte_d;
                        endcase
                    end
                end else begin
                    div_d   = '0;
                    phase_d = 1'b0;
                    sclk_d  = 1'b0;
                    if (bit_q == 6'd0) begin
                        word_d  = asm_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        bit_d = bit_q - 6'd1;
                    end
                end
            end
            S_HOLD: begin
                // flash_clk parked low stretches the SPI clock until the word is taken.
                if (valid_q && word_ready) begin
                    valid_d = 1'b0;
                    rem_d   = rem_q - 32'd4;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (rem_q == 32'd0) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    bit_d   = 6'd31;
                    div_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_READ;
                end
            end
            default: state_d = S_STARTUP;
        endcase
    end

    assign word_out      = word_q;
    assign word_valid    = valid_q;
    assign ready_for_cmd = ready_q;
    assign done          = done_q;
    assign flash_clk     = sclk_q;
    assign flash_mosi    = mosi_q;
    assign flash_cs      = cs_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash model, vector table and a word scoreboard.
module tb_spi_flash_reader;

    localparam int STARTUP_WAIT = 16;
    localparam int CLK_DIV      = 1;
`ifdef FLASH_READER_FAST_READ_EN
    localparam int         CMD_BITS = 40;
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam int         CMD_BITS = 32;
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [23:0] start_address = '0;
    logic [31:0] byte_count = '0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        ready_for_cmd;
    logic        done;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso = 1'b0;
    logic        flash_cs;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    spi_flash_reader #(.STARTUP_WAIT(STARTUP_WAIT), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_address(start_address),
        .byte_count(byte_count), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .ready_for_cmd(ready_for_cmd), .done(done),
        .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
        .flash_cs(flash_cs), .dbg_state(dbg_state)
    );

    // Flash model: captures command bits on rising flash_clk, shifts data out on falling flash_clk.
    logic [7:0]  mem [256];
    logic [39:0] fm_cmd = '0;
    logic [23:0] fm_ptr = '0;
    logic [7:0]  fm_byte;
    int          fm_rc = 0;
    int          fm_bi = 0;
    int          fm_total_rises = 0;

    always @(posedge flash_clk or negedge flash_clk or posedge flash_cs) begin
        if (flash_cs) begin
            fm_rc = 0;
            fm_bi = 0;
        end else if (flash_clk) begin
            if (fm_rc < CMD_BITS) fm_cmd = {fm_cmd[38:0], flash_mosi};
            fm_rc++;
            fm_total_rises++;
            if (fm_rc == CMD_BITS) fm_ptr = fm_cmd[CMD_BITS-9 -: 24];
        end else if (fm_rc >= CMD_BITS) begin
            fm_byte    = mem[fm_ptr[7:0]];
            flash_miso = fm_byte[3'(7 - fm_bi)];
            fm_bi++;
            if (fm_bi == 8) begin
                fm_bi  = 0;
                fm_ptr = fm_ptr + 24'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [31:0] w;
        logic [23:0] ad;
        for (int b = 0; b < 4; b++) begin
            ad = a + 24'(b);
            w[8*b +: 8] = mem[ad[7:0]];
        end
        return w;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready_for_cmd) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'(ready_for_cmd), 32'd1);
    endtask

    task automatic consume();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL word_extra: got %h expected no word", word_out);
        end else begin
            e = exp_q.pop_front();
            check("word", word_out, e);
        end
    endtask

    task automatic run_txn(input logic [23:0] addr, input logic [31:0] count,
                           input int stall, input int exp_words);
        bit ok;
        int words_seen = 0, done_seen = 0, done_cyc = -1, cs_low_seen = 0;
        int last_rise = -1, gap_bad = 0, stalled = 0, stall_bad = 0, rises0;
        logic prev_valid = 1'b0;
        logic [31:0] held = '0;
        wait_ready(ok);
        if (!ok) return;
        for (int w = 0; w < int'(count >> 2); w++) exp_q.push_back(exp_word(addr + 24'(4 * w)));
        rises0        = fm_total_rises;
        start         = 1'b1;
        start_address = addr;
        byte_count    = count;
        word_ready    = (stall == 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (!flash_cs) cs_low_seen = 1;
            if (done) begin
                done_seen++;
                if (done_seen == 1) done_cyc = cyc;
            end
            if (word_valid && !prev_valid) begin
                if (last_rise >= 0 && stall == 0 && (cyc - last_rise) != 66) gap_bad++;
                last_rise = cyc;
            end
            prev_valid = word_valid;
            if (word_valid) begin
                if (!word_ready) begin
                    if (stalled == 0) held = word_out;
                    stalled++;
                    if (word_out !== held || flash_clk !== 1'b0 || flash_cs !== 1'b0) stall_bad++;
                    if (stalled >= stall) begin
                        word_ready = 1'b1;
                        consume();
                        words_seen++;
                    end
                end else begin
                    consume();
                    words_seen++;
                end
            end
            if (done_seen > 0 && cyc > done_cyc + 3) break;
        end
        word_ready = 1'b1;
        check("done_count", 32'(done_seen), 32'd1);
        check("word_count", 32'(words_seen), 32'(exp_words));
        check("cs_idle_after", 32'(flash_cs), 32'd1);
        check("exp_q_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (exp_words == 0) begin
            check("zero_done_latency", 32'(done_cyc), 32'd0);
            check("zero_cs_activity", 32'(cs_low_seen), 32'd0);
        end else begin
            check("cmd_byte", 32'(fm_cmd[CMD_BITS-1 -: 8]), 32'(CMD_BYTE));
            check("cmd_addr", 32'(fm_cmd[CMD_BITS-9 -: 24]), 32'(addr));
`ifdef FLASH_READER_FAST_READ_EN
            check("dummy_mosi", 32'(fm_cmd[7:0]), 32'd0);
`endif
            check("sclk_rises", 32'(fm_total_rises - rises0), 32'(CMD_BITS + 32 * exp_words));
        end
        if (stall > 0) check("stall_stable", 32'(stall_bad), 32'd0);
        if (stall == 0 && exp_words >= 2) check("word_period", 32'(gap_bad), 32'd0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] count;
        int          stall;
        int          exp_words;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   rise, cs_bad, got;
        bit   ok;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h31; mem[1] = 8'h32; mem[2] = 8'h33; mem[3] = 8'h34;
        mem[4] = 8'h0A; mem[5] = 8'h61; mem[6] = 8'h62; mem[7] = 8'h63;

        vecs[0] = '{24'h000000, 32'd8,  0,  2};
        vecs[1] = '{24'h000000, 32'd8,  50, 2};
        vecs[2] = '{24'h000010, 32'd7,  0,  1};
        vecs[3] = '{24'h000000, 32'd0,  0,  0};
        vecs[4] = '{24'hFFFFFE, 32'd8,  0,  2};
        vecs[5] = '{24'h000040, 32'd13, 0,  3};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(flash_cs), 32'd1);
        check("rst_sclk", 32'(flash_clk), 32'd0);
        check("rst_mosi", 32'(flash_mosi), 32'd0);
        check("rst_word", word_out, 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_ready", 32'(ready_for_cmd), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        rst_n  = 1'b1;
        rise   = 0;
        cs_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (!flash_cs) cs_bad = 1;
            if (ready_for_cmd && rise == 0) rise = i;
        end
        check("startup_edge", 32'(rise), 32'(STARTUP_WAIT + 1));
        check("startup_cs", 32'(cs_bad), 32'd0);

        for (int v = 0; v < 6; v++)
            run_txn(vecs[v].addr, vecs[v].count, vecs[v].stall, vecs[v].exp_words);

        // Reset in the middle of the second word's READ, then a clean re-read from byte 0.
        wait_ready(ok);
        if (ok) begin
            start         = 1'b1;
            start_address = 24'h000000;
            byte_count    = 32'd8;
            word_ready    = 1'b1;
            got           = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (word_valid) begin
                    got = 1;
                    break;
                end
            end
            check("rst_txn_w0_seen", 32'(got), 32'd1);
            check("rst_txn_w0", word_out, 32'h34333231);
            repeat (20) @(negedge clk);
            check("rst_txn_cs_active", 32'(flash_cs), 32'd0);
            #2 rst_n = 1'b0;
            #1;
            check("midrst_cs", 32'(flash_cs), 32'd1);
            check("midrst_valid", 32'(word_valid), 32'd0);
            check("midrst_sclk", 32'(flash_clk), 32'd0);
            check("midrst_ready", 32'(ready_for_cmd), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            run_txn(24'h000000, 32'd8, 0, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
